reed_solomon_syndrome_calc: RTL and testbench



---
 rtl/reed_solomon_syndrome_calc.sv | 158 +++++++++++++++
 tb/tb_reed_solomon_syndrome_calc.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reed_solomon_syndrome_calc.sv
// Syndrome stage of the RS(64,48) GF(2^8) decoder: folds one 512-bit line into
// S0..S(NUM_SYN-1) by Horner's rule, SYMS_PER_CYCLE symbols per beat.
module reed_solomon_syndrome_calc #(
   parameter int SYMS_PER_CYCLE = 8,
   parameter int NUM_SYN        = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic [511:0]           data_in,
   input  logic                   valid_in,
   output logic [511:0]           data_out,
   output logic [8*NUM_SYN-1:0]   syn_out,
   output logic                   syn_valid,
   output logic                   error_free,
   output logic                   busy,
   output logic                   overflow,
   output logic [31:0]            line_count
);

   localparam int NUM_BEATS = 64 / SYMS_PER_CYCLE;
   localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam int BEAT_BITS = 8 * SYMS_PER_CYCLE;
   localparam int SYN_BITS  = 8 * NUM_SYN;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [BEAT_W-1:0]     r_beat;
   logic [511:0]          r_line;
   logic [SYN_BITS-1:0]   r_acc;
   logic [SYN_BITS-1:0]   w_acc_next;
   logic [9:0]            w_shamt;
   logic [BEAT_BITS-1:0]  w_beat_syms;
   logic                  w_capture;
   logic                  w_drop;
   logic                  w_done;
   logic                  w_last;

   logic                  r_syn_valid;
   logic [SYN_BITS-1:0]   r_syn_out;
   logic [511:0]          r_data_out;
   logic                  r_error_free;
   logic                  r_overflow;
   logic [31:0]           r_line_count;

   function automatic logic [7:0] gf_xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
   endfunction

   // e is always an elaboration constant, so this collapses to an XOR network.
   function automatic logic [7:0] gf_mul_apow(input logic [7:0] a, input int e);
      logic [7:0] r;
      r = a;
      for (int i = 0; i < (e % 255); i++) r = gf_xtime(r);
      return r;
   endfunction

   // One Horner beat for root alpha^j; byte 0 of syms is the highest-degree symbol.
   function automatic logic [7:0] horner_beat(input logic [7:0] acc,
                                              input logic [BEAT_BITS-1:0] syms,
                                              input int j);
      logic [7:0]           r;
      logic [BEAT_BITS-1:0] t;
      r = gf_mul_apow(acc, j * SYMS_PER_CYCLE);
      t = syms;
      for (int m = 0; m < SYMS_PER_CYCLE; m++) begin
         r = r ^ gf_mul_apow(t[7:0], j * (SYMS_PER_CYCLE - 1 - m));
         t = t >> 8;
      end
      return r;
   endfunction

   assign w_shamt     = 10'(r_beat) * 10'(BEAT_BITS);
   assign w_beat_syms = BEAT_BITS'(r_line >> w_shamt);

   for (genvar j = 0; j < NUM_SYN; j++) begin : g_syn
      assign w_acc_next[8*j +: 8] = horner_beat(r_acc[8*j +: 8], w_beat_syms, j);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // A strobe in S_DONE starts the next line directly, so no idle gap is needed.
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_drop      = 1'b0;
      w_done      = 1'b0;
      w_last      = (r_beat == BEAT_W'(NUM_BEATS - 1));
      case (r_state)
         S_IDLE: begin
            if (valid_in) begin
               w_capture   = 1'b1;
               w_state_nxt = S_CALC;
            end
         end
         S_CALC: begin
            w_drop = valid_in;
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_done = 1'b1;
            if (valid_in) begin
               w_capture   = 1'b1;
               w_state_nxt = S_CALC;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_beat       <= '0;
         r_line       <= '0;
         r_acc        <= '0;
         r_syn_valid  <= 1'b0;
         r_syn_out    <= '0;
         r_data_out   <= '0;
         r_error_free <= 1'b0;
         r_overflow   <= 1'b0;
         r_line_count <= '0;
      end else begin
         if (w_capture) begin
            r_line <= data_in;
            r_acc  <= '0;
            r_beat <= '0;
         end else if (r_state == S_CALC) begin
            r_acc  <= w_acc_next;
            r_beat <= r_beat + BEAT_W'(1);
         end
         r_syn_valid <= w_done;
         if (w_done) begin
            r_syn_out    <= r_acc;
            r_data_out   <= r_line;
            r_error_free <= ~|r_acc;
         end
         // Clear and a same-cycle event combine: a drop still sets, a completion still counts.
         r_line_count <= (clear ? 32'd0 : r_line_count) + 32'(w_done);
         r_overflow   <= (r_overflow & ~clear) | w_drop;
      end
   end

   assign data_out   = r_data_out;
   assign syn_out    = r_syn_out;
   assign syn_valid  = r_syn_valid;
   assign error_free = r_error_free;
   assign busy       = (r_state == S_CALC);
   assign overflow   = r_overflow;
   assign line_count = r_line_count;

endmodule

// File: tb/tb_reed_solomon_syndrome_calc.sv
// Directed bench for reed_solomon_syndrome_calc (default 8 symbols/beat, 16 syndromes).
module tb_reed_solomon_syndrome_calc;

   logic         clk = 1'b0;
   logic         reset;
   logic         clear;
   logic [511:0] data_in;
   logic         valid_in;
   logic [511:0] data_out;
   logic [127:0] syn_out;
   logic         syn_valid;
   logic         error_free;
   logic         busy;
   logic         overflow;
   logic [31:0]  line_count;

   int n_cmp = 0;
   int n_err = 0;

   reed_solomon_syndrome_calc dut (
      .clk(clk), .reset(reset), .clear(clear),
      .data_in(data_in), .valid_in(valid_in),
      .data_out(data_out), .syn_out(syn_out), .syn_valid(syn_valid),
      .error_free(error_free), .busy(busy), .overflow(overflow),
      .line_count(line_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xt(x);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] apow(input int e);
      logic [7:0] p;
      p = 8'h01;
      for (int i = 0; i < e; i++) p = xt(p);
      return p;
   endfunction

   // Direct evaluation S_j = sum_k byte_k * alpha^(j*(63-k)).
   function automatic logic [127:0] syn_model(input logic [511:0] line);
      logic [127:0] res;
      logic [511:0] t;
      logic [7:0]   s;
      res = '0;
      for (int j = 0; j < 16; j++) begin
         s = 8'h00;
         t = line;
         for (int k = 0; k < 64; k++) begin
            s = s ^ gmul(t[7:0], apow((j * (63 - k)) % 255));
            t = t >> 8;
         end
         res = {s, res[127:8]};
      end
      return res;
   endfunction

   function automatic logic [135:0] scale17(input logic [135:0] v, input logic [7:0] a);
      logic [135:0] res, t;
      res = '0; t = v;
      for (int i = 0; i < 17; i++) begin
         res = {gmul(t[7:0], a), res[135:8]};
         t = t >> 8;
      end
      return res;
   endfunction

   // Systematic encoder, generator prod (x + alpha^i), i = 0..15.
   function automatic logic [511:0] mk_codeword();
      logic [135:0] g, sc;
      logic [127:0] par;
      logic [511:0] line;
      logic [7:0]   m, fb;
      g = 136'h1;
      for (int i = 0; i < 16; i++) g = (g << 8) ^ scale17(g, apow(i));
      par = '0; line = '0;
      for (int k = 0; k < 48; k++) begin
         m    = 8'(k * 7 + 3);
         line = {m, line[511:8]};
         fb   = m ^ par[127:120];
         sc   = scale17(g, fb);
         par  = (par << 8) ^ sc[127:0];
      end
      for (int k = 48; k < 64; k++) begin
         line = {par[127:120], line[511:8]};
         par  = par << 8;
      end
      return line;
   endfunction

   function automatic logic [511:0] mk_line(input int seed, input int step);
      logic [511:0] line;
      line = '0;
      for (int k = 0; k < 64; k++) line = {8'(seed + step * k), line[511:8]};
      return line;
   endfunction

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [511:0] d);
      data_in  = d;
      valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
   endtask

   task automatic wait_syn(output int lat);
      lat = 0;
      while (syn_valid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   logic [511:0] line_a, line_b, cw, bad;
   logic [127:0] exp_syn;
   int           lat, hits;

   initial begin
      reset = 1'b1; clear = 1'b0; valid_in = 1'b0; data_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_syn_valid", 512'(syn_valid), 512'(1'b0));
      chk("rst_syn_out", 512'(syn_out), 512'(0));
      chk("rst_data_out", data_out, 512'(0));
      chk("rst_busy_err_ovf", 512'({busy, error_free, overflow}), 512'(3'b000));
      chk("rst_line_count", 512'(line_count), 512'(0));
      reset = 1'b0;
      @(negedge clk);

      // all-zero line
      send('0);
      chk("zero_busy", 512'(busy), 512'(1'b1));
      wait_syn(lat);
      chk("zero_latency", 512'(lat), 512'(9));
      chk("zero_syn", 512'(syn_out), 512'(0));
      chk("zero_error_free", 512'(error_free), 512'(1'b1));
      chk("zero_line_count", 512'(line_count), 512'(1));
      @(negedge clk);
      chk("zero_strobe_once", 512'({syn_valid, busy}), 512'(2'b00));

      // byte 63 = 1 -> every S_j = 1
      line_a = 512'h1 << (8 * 63);
      send(line_a);
      wait_syn(lat);
      chk("b63_syn", 512'(syn_out), 512'({16{8'h01}}));
      chk("b63_error_free", 512'(error_free), 512'(1'b0));
      chk("b63_data_out", data_out, line_a);

      // byte 62 = 1 -> S_j = alpha^j
      line_a = 512'h1 << (8 * 62);
      send(line_a);
      wait_syn(lat);
      chk("b62_syn", 512'(syn_out),
          512'(128'h26_13_87_CD_E8_74_3A_1D_80_40_20_10_08_04_02_01));

      // valid codeword, then byte 10 corrupted by 0x5A
      cw = mk_codeword();
      send(cw);
      wait_syn(lat);
      chk("cw_error_free", 512'(error_free), 512'(1'b1));
      chk("cw_syn", 512'(syn_out), 512'(0));
      chk("cw_data_out", data_out, cw);
      bad = cw ^ (512'h5A << 80);
      exp_syn = '0;
      for (int j = 0; j < 16; j++) exp_syn = {gmul(8'h5A, apow((53 * j) % 255)), exp_syn[127:8]};
      send(bad);
      wait_syn(lat);
      chk("bad_syn", 512'(syn_out), 512'(exp_syn));
      chk("bad_s0", 512'(syn_out[7:0]), 512'(8'h5A));
      chk("bad_error_free", 512'(error_free), 512'(1'b0));
      chk("bad_line_count", 512'(line_count), 512'(5));

      // 13-cycle spacing
      line_a = mk_line(17, 3);
      line_b = mk_line(200, 11);
      send(line_a);
      wait_syn(lat);
      chk("sp13_a_latency", 512'(lat), 512'(9));
      chk("sp13_a_syn", 512'(syn_out), 512'(syn_model(line_a)));
      repeat (3) @(negedge clk);
      send(line_b);
      wait_syn(lat);
      chk("sp13_b_latency", 512'(lat), 512'(9));
      chk("sp13_b_syn", 512'(syn_out), 512'(syn_model(line_b)));
      chk("sp13_overflow", 512'(overflow), 512'(1'b0));

      // 9-cycle spacing: second strobe lands in S_DONE
      line_a = mk_line(5, 29);
      line_b = mk_line(99, 1);
      send(line_a);
      repeat (8) @(negedge clk);
      send(line_b);
      chk("sp9_a_valid", 512'(syn_valid), 512'(1'b1));
      chk("sp9_a_syn", 512'(syn_out), 512'(syn_model(line_a)));
      chk("sp9_a_data", data_out, line_a);
      chk("sp9_b_busy", 512'(busy), 512'(1'b1));
      @(negedge clk);
      wait_syn(lat);
      chk("sp9_b_latency", 512'(lat), 512'(8));
      chk("sp9_b_syn", 512'(syn_out), 512'(syn_model(line_b)));
      chk("sp9_b_data", data_out, line_b);
      chk("sp9_overflow_count", 512'({overflow, line_count}), 512'({1'b0, 32'd9}));

      // line arriving 3 cycles after the first is dropped
      line_a = mk_line(1, 77);
      line_b = mk_line(250, 13);
      send(line_a);
      repeat (2) @(negedge clk);
      send(line_b);
      wait_syn(lat);
      chk("drop_latency", 512'(lat), 512'(6));
      chk("drop_syn", 512'(syn_out), 512'(syn_model(line_a)));
      chk("drop_data", data_out, line_a);
      chk("drop_overflow", 512'(overflow), 512'(1'b1));
      hits = 0;
      repeat (15) begin
         @(negedge clk);
         if (syn_valid) hits++;
      end
      chk("drop_no_second_strobe", 512'(hits), 512'(0));

      // clear together with a drop: overflow set wins
      line_a = mk_line(42, 5);
      send(line_a);
      @(negedge clk);
      data_in = mk_line(3, 3); valid_in = 1'b1; clear = 1'b1;
      @(negedge clk);
      valid_in = 1'b0; clear = 1'b0;
      chk("clrdrop_overflow", 512'(overflow), 512'(1'b1));
      chk("clrdrop_count", 512'(line_count), 512'(0));
      wait_syn(lat);
      chk("clrdrop_syn", 512'(syn_out), 512'(syn_model(line_a)));
      chk("clrdrop_data", data_out, line_a);
      chk("clrdrop_count_after", 512'(line_count), 512'(1));
      @(negedge clk);

      // clear in the S_DONE cycle: count becomes 1
      line_b = mk_line(123, 45);
      send(line_b);
      repeat (8) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("clrdone_valid", 512'(syn_valid), 512'(1'b1));
      chk("clrdone_count", 512'(line_count), 512'(1));
      chk("clrdone_syn", 512'(syn_out), 512'(syn_model(line_b)));

      // plain clear
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("clear_overflow_count", 512'({overflow, line_count}), 512'({1'b0, 32'd0}));

      // reset in the middle of a line
      send(mk_line(9, 9));
      send(mk_line(8, 8));
      chk("pre_rst_overflow", 512'(overflow), 512'(1'b1));
      reset = 1'b1;
      #1;
      chk("midrst_busy_ovf_ef", 512'({busy, overflow, error_free, syn_valid}), 512'(4'b0000));
      chk("midrst_syn", 512'(syn_out), 512'(0));
      chk("midrst_data", data_out, 512'(0));
      chk("midrst_count", 512'(line_count), 512'(0));
      @(negedge clk);
      reset = 1'b0;
      hits = 0;
      repeat (15) begin
         @(negedge clk);
         if (syn_valid) hits++;
      end
      chk("midrst_no_strobe", 512'(hits), 512'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
